fb_write_arbiter: RTL and testbench
===================================

Name: fb_write_arbiter

Overview:
Write-port arbiter and sequencer for the dual-port framebuffer, in the clk_25 domain between the camera pixel writer and the framebuffer write port.
- Shares the single write port among three requesters: camera stream (highest priority), frame-clear engine, and a handshaked overlay requester (lowest priority).
- The clear engine fills every framebuffer address with a programmable pixel value on command.
- All framebuffer write outputs are registered.

Parameters:
ADDR_WIDTH, 15, framebuffer address width (QQVGA 160x120 fits in 2^15)
FB_DEPTH, 19200, number of valid framebuffer addresses; clear covers 0..FB_DEPTH-1

Ports:
clk_25  input  1  system clock, 25 MHz
reset_n  input  1  asynchronous active-low reset
cam_we  input  1  camera write strobe, single-cycle, never stalled
cam_addr  input  ADDR_WIDTH  camera write address
cam_pixel  input  1  camera pixel value
clear_start  input  1  pulse; starts a full-frame clear
clear_value  input  1  pixel value written during clear; sampled on accepted clear_start
ovl_req  input  1  overlay write request; held until ovl_ack
ovl_addr  input  ADDR_WIDTH  overlay address; stable while ovl_req is high
ovl_pixel  input  1  overlay pixel; stable while ovl_req is high
ovl_ack  output  1  one-cycle acknowledge of an overlay write
clear_busy  output  1  high while the clear sequence is active
clear_done  output  1  one-cycle pulse when the last clear address is written
fb_we  output  1  framebuffer write enable
fb_addr  output  ADDR_WIDTH  framebuffer write address
fb_data  output  1  framebuffer write data

Behaviour:
- Reset (async, reset_n low): every output is 0. State is IDLE, clear counter is 0, latched clear value is 0. Asserting reset mid-clear aborts the clear; no clear_done is issued.
- State machine:
  - IDLE -> CLEAR on clear_start. clear_value is latched; counter is set to 0; clear_busy goes high on the next cycle.
  - CLEAR -> IDLE on the cycle the counter value FB_DEPTH-1 is granted. clear_done pulses and clear_busy drops on the following cycle, both in the same cycle.
  - clear_start is ignored while clear_busy is high, including its final cycle. There is no re-arm.
- Grant, evaluated combinationally each cycle, strict priority:
  1. cam_we: always granted.
  2. Clear: granted when state is CLEAR and cam_we is low.
  3. Overlay: granted when ovl_req is high, ovl_ack is low, cam_we is low, and no clear grant is issued.
- Output registration: on the edge after a grant, fb_we=1 and fb_addr/fb_data take the granted source's values. With no grant, fb_we=0 and fb_addr/fb_data hold their previous values. Latency is exactly 1 cycle for every source.
- Clear counter: advances by 1 only on cycles where clear is granted. A camera write stalls the clear without skipping an address.
- Overlay handshake: ovl_ack is registered and asserted in the same cycle fb_we carries the overlay write. While ack is high, the requester may drop ovl_req or present the next request. Because the grant condition excludes ovl_ack=1, the same request cannot be granted twice. The overlay starves for the whole duration of a clear.
- A clear_start arriving in the same cycle as cam_we: the clear is accepted, and the camera write proceeds as normal.
- A camera address >= FB_DEPTH is passed through unchanged when FB_ARB_BOUNDS_EN is absent.

Optional Feature:
Macro FB_ARB_BOUNDS_EN.
- Defined:
  - Any granted camera or overlay write with address >= FB_DEPTH is suppressed (fb_we stays 0).
  - An overlay write suppressed this way is still acknowledged.
  - Adds output addr_err (1 bit, reset 0). It sets sticky on any suppression and clears only on reset or on an accepted clear_start.
- Undefined: no address check is made, and the addr_err port does not exist.

Test Plan:
1. Reset, then cam_we=1, cam_addr=0x0123, cam_pixel=1 for one cycle -> the next cycle shows fb_we=1, fb_addr=0x0123, fb_data=1; the following cycle shows fb_we=0.
2. Clear with no traffic: clear_start with clear_value=1 -> exactly 19200 consecutive fb_we cycles at addresses 0..19199 with data 1, a clear_done pulse coincident with clear_busy falling, and no further writes.
3. Clear interleaved with camera writes: cam_we asserted on every third cycle -> the camera writes appear at 1-cycle latency. Clear addresses remain contiguous with no gaps or repeats, and clear_done arrives after 19200 clear grants.
4. Overlay handshake: ovl_req held with ovl_addr=0x0050, ovl_pixel=1, colliding with one cam_we cycle -> the camera write goes first, then exactly one overlay write with ovl_ack high in that same cycle. Holding ovl_req for one extra cycle after ack produces a second, distinct write only on the following cycle.
5. Reset mid-clear: reset_n pulsed low at clear address 5000 -> all outputs are 0 immediately, no clear_done follows, and a subsequent clear_start restarts from address 0.
6. With FB_ARB_BOUNDS_EN defined: cam_we with cam_addr=19200 -> fb_we stays 0 and addr_err=1 sticky. addr_err clears on the next accepted clear_start.

Source files
------------

// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port arbiter: camera > clear engine > overlay, with full-frame clear sequencer.
// Optional address bounds checking (and the addr_err port) is enabled by defining FB_ARB_BOUNDS_EN.
module fb_write_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int FB_DEPTH   = 19200
) (
  input  logic                  clk_25,
  input  logic                  reset_n,
  input  logic                  cam_we,
  input  logic [ADDR_WIDTH-1:0] cam_addr,
  input  logic                  cam_pixel,
  input  logic                  clear_start,
  input  logic                  clear_value,
  input  logic                  ovl_req,
  input  logic [ADDR_WIDTH-1:0] ovl_addr,
  input  logic                  ovl_pixel,
  output logic                  ovl_ack,
  output logic                  clear_busy,
  output logic                  clear_done,
`ifdef FB_ARB_BOUNDS_EN
  output logic                  addr_err,
`endif
  output logic                  fb_we,
  output logic [ADDR_WIDTH-1:0] fb_addr,
  output logic                  fb_data
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_DEPTH - 1);

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] clr_cnt_r;
  logic                  clr_val_r;

  logic                  clr_gnt_s;
  logic                  ovl_gnt_s;
  logic                  wr_en_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s;
  logic                  wr_data_s;
  logic                  clr_accept_s;
  logic                  oob_s;

  // Strict-priority grant and write-source mux
  always_comb begin
    clr_gnt_s = 1'b0;
    ovl_gnt_s = 1'b0;
    wr_en_s   = 1'b0;
    wr_addr_s = fb_addr;
    wr_data_s = fb_data;
    if (cam_we) begin
      wr_en_s   = 1'b1;
      wr_addr_s = cam_addr;
      wr_data_s = cam_pixel;
    end else if (state_r == ST_CLEAR) begin
      clr_gnt_s = 1'b1;
      wr_en_s   = 1'b1;
      wr_addr_s = clr_cnt_r;
      wr_data_s = clr_val_r;
    end else if (ovl_req && !ovl_ack) begin
      ovl_gnt_s = 1'b1;
      wr_en_s   = 1'b1;
      wr_addr_s = ovl_addr;
      wr_data_s = ovl_pixel;
    end else begin
      wr_en_s   = 1'b0;
    end
  end

  assign clr_accept_s = (state_r == ST_IDLE) && clear_start;

`ifdef FB_ARB_BOUNDS_EN
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(FB_DEPTH);

  // Flag granted camera/overlay writes that fall outside the frame
  always_comb begin
    if ((cam_we || ovl_gnt_s) && ({1'b0, wr_addr_s} >= DEPTH_EXT)) begin
      oob_s = 1'b1;
    end else begin
      oob_s = 1'b0;
    end
  end

  // Sticky address error; a suppression in the same cycle as a new clear wins
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      addr_err <= 1'b0;
    end else if (oob_s) begin
      addr_err <= 1'b1;
    end else if (clr_accept_s) begin
      addr_err <= 1'b0;
    end
  end
`else
  assign oob_s = 1'b0;
`endif

  // Clear sequencer state and registered write-port outputs
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      clr_cnt_r  <= '0;
      clr_val_r  <= 1'b0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
      ovl_ack    <= 1'b0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= 1'b0;
    end else begin
      fb_we      <= wr_en_s && !oob_s;
      ovl_ack    <= ovl_gnt_s;
      clear_done <= 1'b0;
      if (wr_en_s && !oob_s) begin
        fb_addr <= wr_addr_s;
        fb_data <= wr_data_s;
      end
      case (state_r)
        ST_IDLE: begin
          if (clr_accept_s) begin
            state_r    <= ST_CLEAR;
            clr_cnt_r  <= '0;
            clr_val_r  <= clear_value;
            clear_busy <= 1'b1;
          end
        end
        ST_CLEAR: begin
          // A camera write stalls the counter, so no address is skipped
          if (clr_gnt_s) begin
            clr_cnt_r <= clr_cnt_r + ADDR_WIDTH'(1);
            if (clr_cnt_r == LAST_ADDR) begin
              state_r    <= ST_IDLE;
              clear_busy <= 1'b0;
              clear_done <= 1'b1;
            end
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          clear_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: vector table plus clear, overlay, reset and bounds sequences.
module tb_fb_write_arbiter;

  localparam int AW    = 15;
  localparam int DEPTH = 19200;

  logic          clk_25 = 1'b0;
  logic          reset_n = 1'b1;
  logic          cam_we, cam_pixel, clear_start, clear_value, ovl_req, ovl_pixel;
  logic [AW-1:0] cam_addr, ovl_addr;
  logic          ovl_ack, clear_busy, clear_done, fb_we, fb_data;
  logic [AW-1:0] fb_addr;
`ifdef FB_ARB_BOUNDS_EN
  logic          addr_err;
`endif

  int total = 0;
  int bad   = 0;

  fb_write_arbiter #(.ADDR_WIDTH(AW), .FB_DEPTH(DEPTH)) dut (
    .clk_25(clk_25), .reset_n(reset_n),
    .cam_we(cam_we), .cam_addr(cam_addr), .cam_pixel(cam_pixel),
    .clear_start(clear_start), .clear_value(clear_value),
    .ovl_req(ovl_req), .ovl_addr(ovl_addr), .ovl_pixel(ovl_pixel),
    .ovl_ack(ovl_ack), .clear_busy(clear_busy), .clear_done(clear_done),
`ifdef FB_ARB_BOUNDS_EN
    .addr_err(addr_err),
`endif
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data)
  );

  always #20 clk_25 = ~clk_25;

  typedef struct {
    logic          cam_we;
    logic [AW-1:0] cam_addr;
    logic          cam_pixel;
    logic          ovl_req;
    logic [AW-1:0] ovl_addr;
    logic          ovl_pixel;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic          exp_data;
    logic          exp_ack;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_25);
    #1;
  endtask

  task automatic idle_inputs();
    cam_we = 1'b0; cam_addr = '0; cam_pixel = 1'b0;
    clear_start = 1'b0; clear_value = 1'b0;
    ovl_req = 1'b0; ovl_addr = '0; ovl_pixel = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    #3 reset_n = 1'b0;
    repeat (2) @(posedge clk_25);
    #5 reset_n = 1'b1;
  endtask

  // Clear run with optional periodic camera traffic; clear_start is held high throughout
  // the clear (must be ignored) and clear_value is flipped after the start (must not matter).
  task automatic run_clear(input int cam_period, input logic cval,
                           output int errs, output int clr_writes, output int dones);
    int cnt;
    int i;
    int tail;
    logic clearing;
    logic cam;
    logic [AW-1:0] caddr;
    logic e_we, e_data, e_done;
    logic [AW-1:0] e_addr;
    cnt = 0; i = 0; tail = 0; clearing = 1'b0;
    errs = 0; clr_writes = 0; dones = 0;
    while (tail < 20 && i < 3 * DEPTH) begin
      cam   = (cam_period != 0) && (i % cam_period == 0);
      caddr = AW'(256 + (i % 64));
      cam_we = cam; cam_addr = caddr; cam_pixel = ~cval;
      clear_start = (i == 0) || clearing;
      clear_value = (i == 0) ? cval : ~cval;
      tick();
      e_we = 1'b0; e_addr = '0; e_data = 1'b0; e_done = 1'b0;
      if (cam) begin
        e_we = 1'b1; e_addr = caddr; e_data = ~cval;
      end else if (clearing) begin
        e_we = 1'b1; e_addr = AW'(cnt); e_data = cval;
        clr_writes++;
        if (cnt == DEPTH - 1) begin
          e_done = 1'b1;
          clearing = 1'b0;
        end
        cnt++;
      end
      if (i == 0) clearing = 1'b1;
      if (!clearing && i > 0) tail++;
      if (fb_we !== e_we || (e_we && (fb_addr !== e_addr || fb_data !== e_data)) ||
          clear_done !== e_done || clear_busy !== clearing || ovl_ack !== 1'b0) begin
        if (errs < 4)
          $display("FAIL clr_cycle%0d: got we=%b addr=%0d data=%b done=%b busy=%b expected we=%b addr=%0d data=%b done=%b busy=%b",
                   i, fb_we, fb_addr, fb_data, clear_done, clear_busy, e_we, e_addr, e_data, e_done, clearing);
        errs++;
      end
      dones += int'(clear_done);
      i++;
    end
    idle_inputs();
  endtask

  initial begin
    int errs, wr, dn, n;
    idle_inputs();

    vecs[0] = '{1'b1, 15'h0123, 1'b1, 1'b0, 15'h0000, 1'b0, 1'b1, 15'h0123, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 1'b0, 1'b0, 15'h0123, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 15'h0000, 1'b0, 1'b1, 15'h0050, 1'b1, 1'b1, 15'h0050, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 15'h0000, 1'b0, 1'b1, 15'h0050, 1'b1, 1'b0, 15'h0050, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 15'h4AFF, 1'b0, 1'b1, 15'h0051, 1'b0, 1'b1, 15'h4AFF, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 15'h0000, 1'b0, 1'b1, 15'h0051, 1'b0, 1'b1, 15'h0051, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 15'h0000, 1'b0, 1'b1, 15'h0051, 1'b0, 1'b0, 15'h0051, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 15'h0000, 1'b0, 1'b1, 15'h0051, 1'b0, 1'b1, 15'h0051, 1'b0, 1'b1};
    vecs[8] = '{1'b1, 15'h0000, 1'b1, 1'b0, 15'h0000, 1'b0, 1'b1, 15'h0000, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 1'b1, 1'b0};

    #5 reset_n = 1'b0;
    #5;
    check("reset_outputs", 32'({fb_we, fb_addr, fb_data, ovl_ack, clear_busy, clear_done}), 32'd0);
    @(posedge clk_25);
    #5 reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      cam_we = vecs[i].cam_we; cam_addr = vecs[i].cam_addr; cam_pixel = vecs[i].cam_pixel;
      ovl_req = vecs[i].ovl_req; ovl_addr = vecs[i].ovl_addr; ovl_pixel = vecs[i].ovl_pixel;
      tick();
      check($sformatf("vec%0d", i), 32'({fb_we, fb_addr, fb_data, ovl_ack}),
            32'({vecs[i].exp_we, vecs[i].exp_addr, vecs[i].exp_data, vecs[i].exp_ack}));
    end
    idle_inputs();

    do_reset();
    run_clear(0, 1'b1, errs, wr, dn);
    check("clear_plain_errs", 32'(errs), 32'd0);
    check("clear_plain_writes", 32'(wr), 32'd19200);
    check("clear_plain_dones", 32'(dn), 32'd1);

    do_reset();
    run_clear(3, 1'b0, errs, wr, dn);
    check("clear_cam_errs", 32'(errs), 32'd0);
    check("clear_cam_writes", 32'(wr), 32'd19200);
    check("clear_cam_dones", 32'(dn), 32'd1);

    // Reset mid-clear
    do_reset();
    clear_start = 1'b1; clear_value = 1'b1;
    tick();
    clear_start = 1'b0;
    n = 0;
    while (!(fb_we === 1'b1 && fb_addr === AW'(5000)) && n < 6000) begin
      tick();
      n++;
    end
    check("rst_reach_5000", 32'(fb_addr), 32'd5000);
    #5 reset_n = 1'b0;
    #1;
    check("rst_mid_outputs", 32'({fb_we, fb_addr, fb_data, ovl_ack, clear_busy, clear_done}), 32'd0);
    @(posedge clk_25);
    #5 reset_n = 1'b1;
    dn = 0; wr = 0;
    repeat (30) begin
      tick();
      dn += int'(clear_done);
      wr += int'(fb_we);
    end
    check("rst_no_done", 32'(dn), 32'd0);
    check("rst_no_write", 32'(wr), 32'd0);
    clear_start = 1'b1; clear_value = 1'b0;
    tick();
    clear_start = 1'b0;
    check("restart_busy", 32'({clear_busy, fb_we}), 32'b10);
    tick();
    check("restart_addr0", 32'({fb_we, fb_addr, fb_data}), 32'({1'b1, 15'd0, 1'b0}));
    tick();
    check("restart_addr1", 32'({fb_we, fb_addr, fb_data}), 32'({1'b1, 15'd1, 1'b0}));

    // Out-of-range camera address
    do_reset();
    cam_we = 1'b1; cam_addr = AW'(19200); cam_pixel = 1'b1;
    tick();
    idle_inputs();
`ifdef FB_ARB_BOUNDS_EN
    check("oob_cam_suppressed", 32'({fb_we, addr_err}), 32'b01);
    tick();
    check("oob_sticky", 32'({fb_we, addr_err}), 32'b01);
    ovl_req = 1'b1; ovl_addr = AW'(19300); ovl_pixel = 1'b1;
    tick();
    ovl_req = 1'b0;
    check("oob_ovl_acked", 32'({fb_we, ovl_ack, addr_err}), 32'b011);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    check("oob_cleared", 32'({clear_busy, addr_err}), 32'b10);
`else
    check("oob_passthrough", 32'({fb_we, fb_addr, fb_data}), 32'({1'b1, 15'd19200, 1'b1}));
`endif
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
